// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and helpers for the SHA-256 message schedule.
//   word_t     32-bit schedule word
//   state_e    scheduler FSM states {IDLE, RUN}
//   WIN_DEPTH  depth of the sliding schedule window (16 words)
//   sigma0/1   small-sigma functions used by the schedule recurrence
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int WIN_DEPTH = 16;

  // s0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sigma.sv
// sha256_sigma: combinational SHA-256 small-sigma pair.
// Ports:
//   x   in  32  operand
//   s0  out 32  ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
//   s1  out 32  ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
module sha256_sigma
  import sha256_pkg::*;
(
  input  word_t x,
  output word_t s0,
  output word_t s1
);

  assign s0 = sigma0(x);
  assign s1 = sigma1(x);

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message schedule generator.
// Accepts one 512-bit block (M0 in bits 511:480) and streams ROUNDS schedule
// words W[0..ROUNDS-1] with a valid/ready handshake, one word per cycle when
// the consumer never stalls. A 16-word sliding window holds W[t..t+15].
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   blk_valid  in   upstream offers blk_data
//   blk_ready  out  block accepted when blk_valid & blk_ready
//   blk_data   in   512-bit message block
//   w_valid    out  w_data/w_idx/w_last valid
//   w_ready    in   word consumed when w_valid & w_ready
//   w_data     out  schedule word W[t]
//   w_idx      out  round index t
//   w_last     out  w_idx == ROUNDS-1
//
// Parameter ROUNDS: words per block, legal range 16..64.
// Build option SHA256_SCHED_OVERLAP_EN: when defined, a new block may be
// accepted on the same cycle the last word is consumed, removing the idle
// cycle between blocks.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int unsigned ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  localparam logic [5:0] LastIdx = 6'(ROUNDS - 1);

  state_e     state_q, state_d;
  word_t      window_q [WIN_DEPTH];
  word_t      window_d [WIN_DEPTH];
  word_t      load_win [WIN_DEPTH];
  word_t      shift_win[WIN_DEPTH];
  logic [5:0] t_q, t_d;

  word_t s0_w1;
  word_t s1_w1_unused;
  word_t s1_w14;
  word_t w_new;
  logic  is_last;
  logic  w_hs;
  logic  blk_acc;

  // The recurrence needs sigma terms of two different taps each cycle; the
  // instance covers the s0 tap and the package function covers the s1 tap.
  sha256_sigma u_sigma (
    .x  (window_q[1]),
    .s0 (s0_w1),
    .s1 (s1_w1_unused)
  );

  assign s1_w14 = sigma1(window_q[14]);
  assign w_new  = s1_w14 + window_q[9] + s0_w1 + window_q[0];

  assign w_valid = (state_q == RUN);
  assign is_last = w_valid && (t_q == LastIdx);
  assign w_data  = w_valid ? window_q[0] : '0;
  assign w_idx   = w_valid ? t_q : '0;
  assign w_last  = is_last;
  assign w_hs    = w_valid & w_ready;

`ifdef SHA256_SCHED_OVERLAP_EN
  assign blk_ready = (state_q == IDLE) | (w_hs & is_last);
`else
  assign blk_ready = (state_q == IDLE);
`endif

  assign blk_acc = blk_valid & blk_ready;

  // Window images for a fresh block and for a one-word advance.
  always_comb begin
    for (int k = 0; k < WIN_DEPTH; k++) begin
      load_win[k] = blk_data[511 - 32 * k -: 32];
    end
    for (int k = 0; k < WIN_DEPTH - 1; k++) begin
      shift_win[k] = window_q[k + 1];
    end
    shift_win[WIN_DEPTH - 1] = w_new;
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (blk_acc) begin
          window_d = load_win;
          t_d      = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (w_hs) begin
          if (is_last) begin
            t_d = '0;
            // blk_acc can only be set here in the overlap build.
            if (blk_acc) begin
              window_d = load_win;
            end else begin
              state_d = IDLE;
            end
          end else begin
            window_d = shift_win;
            t_d      = t_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int k = 0; k < WIN_DEPTH; k++) begin
        window_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      window_q <= window_d;
    end
  end

endmodule
